// File: rtl/riscv_irq_arbiter.sv
// Platform interrupt arbiter: per-source gateways, priority arbitration and
// claim/complete registers. Define RISCV_IRQ_EDGE_EN to add edge-triggered sources.

module riscv_irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  input  logic claim_i,
  input  logic cmpl_i,
  output logic pend_o
);
  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_CLAIMED} gw_state_e;

  gw_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GW_IDLE;
    else        state_q <= state_d;
  end

  // Trigger is ignored while CLAIMED, so a held level re-pends only after complete
  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE:    if (trig_i)  state_d = GW_PEND;
      GW_PEND:    if (claim_i) state_d = GW_CLAIMED;
      GW_CLAIMED: if (cmpl_i)  state_d = GW_IDLE;
      default:                 state_d = GW_IDLE;
    endcase
  end

  assign pend_o = (state_q == GW_PEND);
endmodule

module riscv_irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               bus_req,
  input  logic               bus_we,
  input  logic [5:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               ext_irq,
  output logic [4:0]         claim_id
);
  logic [NUM_SRC-1:0]             s1_q, s2_q;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]             en_q, en_d;
  logic [PRIO_W-1:0]              thr_q, thr_d;
  logic [NUM_SRC-1:0]             pend, trig, claim_vec, cmpl_vec;
  logic [4:0]                     win_id, claim_id_q, claim_id_d;
  logic [PRIO_W-1:0]              win_prio;
  logic                           claim_hit;
  logic                           ext_irq_q, bus_ack_q;
  logic [31:0]                    bus_rdata_q, bus_rdata_d;
  logic [31:0]                    pend_word, en_word;
  logic                           unused_wdata;

  assign unused_wdata = ^bus_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= src_irq;
      s2_q <= s1_q;
    end
  end

`ifdef RISCV_IRQ_EDGE_EN
  logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d, edge_flag_q, edge_flag_d, s3_q;
  logic [31:0]        edge_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_q        <= '0;
      edge_mode_q <= '0;
      edge_flag_q <= '0;
    end else begin
      s3_q        <= s2_q;
      edge_mode_q <= edge_mode_d;
      edge_flag_q <= edge_flag_d;
    end
  end

  // One-deep edge memory; a new edge in the claim cycle survives the clear
  always_comb begin
    edge_flag_d = (edge_mode_q & s2_q & ~s3_q) | (edge_flag_q & ~claim_vec);
    edge_word   = '0;
    edge_word[NUM_SRC:1] = edge_mode_q;
  end

  assign trig = (edge_mode_q & edge_flag_q) | (~edge_mode_q & s2_q);
`else
  assign trig = s2_q;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    riscv_irq_gateway u_gw (
      .clk    (clk),
      .rst_n  (rst_n),
      .trig_i (trig[g]),
      .claim_i(claim_vec[g]),
      .cmpl_i (cmpl_vec[g]),
      .pend_o (pend[g])
    );
  end

  // Strict compare keeps the lowest ID on ties and excludes priority 0
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend[i] && en_q[i] && (prio_q[i] > win_prio)) begin
        win_prio = prio_q[i];
        win_id   = 5'(i + 1);
      end
    end
  end

  assign claim_hit = (win_prio > thr_q);

  always_comb begin
    pend_word = '0;
    en_word   = '0;
    pend_word[NUM_SRC:1] = pend;
    en_word[NUM_SRC:1]   = en_q;
  end

  always_comb begin
    prio_d      = prio_q;
    en_d        = en_q;
    thr_d       = thr_q;
    claim_id_d  = claim_id_q;
    claim_vec   = '0;
    cmpl_vec    = '0;
    bus_rdata_d = '0;
`ifdef RISCV_IRQ_EDGE_EN
    edge_mode_d = edge_mode_q;
`endif
    if (bus_req) begin
      if (!bus_addr[5]) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus_addr[4:0] == 5'(i + 1)) begin
            bus_rdata_d = 32'(prio_q[i]);
            if (bus_we) prio_d[i] = bus_wdata[PRIO_W-1:0];
          end
        end
      end else begin
        case (bus_addr[4:0])
          5'h00: bus_rdata_d = pend_word;
          5'h01: begin
            bus_rdata_d = en_word;
            if (bus_we) en_d = bus_wdata[NUM_SRC:1];
          end
          5'h02: begin
            bus_rdata_d = 32'(thr_q);
            if (bus_we) thr_d = bus_wdata[PRIO_W-1:0];
          end
          5'h03: begin
            if (bus_we) begin
              for (int i = 0; i < NUM_SRC; i++)
                if (bus_wdata[4:0] == 5'(i + 1)) cmpl_vec[i] = 1'b1;
            end else if (claim_hit) begin
              bus_rdata_d = 32'(win_id);
              claim_id_d  = win_id;
              for (int i = 0; i < NUM_SRC; i++)
                if (win_id == 5'(i + 1)) claim_vec[i] = 1'b1;
            end
          end
`ifdef RISCV_IRQ_EDGE_EN
          5'h04: begin
            bus_rdata_d = edge_word;
            if (bus_we) edge_mode_d = bus_wdata[NUM_SRC:1];
          end
`endif
          default: ;
        endcase
      end
      if (bus_we) bus_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= '0;
      en_q        <= '0;
      thr_q       <= '0;
      claim_id_q  <= '0;
      ext_irq_q   <= 1'b0;
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      prio_q      <= prio_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      claim_id_q  <= claim_id_d;
      ext_irq_q   <= claim_hit;
      bus_ack_q   <= bus_req;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  assign ext_irq   = ext_irq_q;
  assign bus_ack   = bus_ack_q;
  assign bus_rdata = bus_rdata_q;
  assign claim_id  = claim_id_q;
endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Bench for riscv_irq_arbiter: register-map vector table plus claim/complete,
// threshold, reset and (with RISCV_IRQ_EDGE_EN) edge-mode sequences.
module tb_riscv_irq_arbiter;
  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] src_irq;
  logic               bus_req, bus_we;
  logic [5:0]         bus_addr;
  logic [31:0]        bus_wdata, bus_rdata;
  logic               bus_ack, ext_irq;
  logic [4:0]         claim_id;

  riscv_irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_irq(src_irq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .ext_irq(ext_irq), .claim_id(claim_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

`ifdef RISCV_IRQ_EDGE_EN
  localparam logic [31:0] EDGE_RB = 32'h2;
`else
  localparam logic [31:0] EDGE_RB = 32'h0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every access pushes its expected rdata; the ack pops it
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_ack) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else chk(name_q.pop_front(), bus_rdata, exp_q.pop_front());
      end else begin
        chk("rdata_idle", bus_rdata, 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back(32'd0); name_q.push_back($sformatf("wr_%0h", a));
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e); name_q.push_back(nm);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    bus_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1);
    if (exp_q.size() != 0) begin
      chk("ack_timeout", exp_q.size(), 32'd0);
      exp_q.delete(); name_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    src_irq = '0; rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; src_irq = '0; bus_req = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    #3;
    chk("rst_ext_irq", 32'(ext_irq), 0);
    chk("rst_bus_ack", 32'(bus_ack), 0);
    chk("rst_bus_rdata", bus_rdata, 0);
    chk("rst_claim_id", 32'(claim_id), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Register map vectors
    tbl.push_back('{1'b0, 6'h01, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h20, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h21, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h22, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h23, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h24, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 6'h01, 32'hFF,       32'h0});
    tbl.push_back('{1'b0, 6'h01, 32'h0,        32'h7});
    tbl.push_back('{1'b1, 6'h00, 32'h5,        32'h0});
    tbl.push_back('{1'b0, 6'h00, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 6'h09, 32'h5,        32'h0});
    tbl.push_back('{1'b0, 6'h09, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 6'h08, 32'h2,        32'h0});
    tbl.push_back('{1'b0, 6'h08, 32'h0,        32'h2});
    tbl.push_back('{1'b1, 6'h21, 32'hFFFFFFFF, 32'h0});
    tbl.push_back('{1'b0, 6'h21, 32'h0,        32'h1FE});
    tbl.push_back('{1'b1, 6'h22, 32'hF,        32'h0});
    tbl.push_back('{1'b0, 6'h22, 32'h0,        32'h7});
    tbl.push_back('{1'b1, 6'h30, 32'hFFFF,     32'h0});
    tbl.push_back('{1'b0, 6'h30, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 6'h23, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 6'h24, 32'h2,        32'h0});
    tbl.push_back('{1'b0, 6'h24, 32'h0,        EDGE_RB});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      else rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl_%0d_rd_%0h", i, tbl[i].addr));
    end

    // Single source: latency, pending, claim, complete handling
    do_reset();
    wr(6'h03, 32'd5);
    wr(6'h21, 32'h08);
    src_irq[2] = 1'b1;
    cyc(3);
    chk("lat_ext_irq_early", 32'(ext_irq), 0);
    cyc(1);
    chk("lat_ext_irq_4th", 32'(ext_irq), 1);
    rd(6'h20, 32'h08, "pending_src3");
    rd(6'h23, 32'd3, "claim_src3");
    chk("claim_id_3", 32'(claim_id), 3);
    cyc(1);
    chk("ext_irq_after_claim", 32'(ext_irq), 0);
    rd(6'h23, 32'd0, "claim_none");
    wr(6'h23, 32'd6);
    rd(6'h20, 32'h0, "pending_after_cmpl6");
    wr(6'h23, 32'd3);
    cyc(1);
    rd(6'h20, 32'h08, "repend_src3");

    // Priority and tie-break, back-to-back claims
    do_reset();
    wr(6'h01, 32'd2);
    wr(6'h02, 32'd2);
    wr(6'h05, 32'd6);
    wr(6'h21, 32'h26);
    src_irq = 8'h13;
    cyc(4);
    chk("prio_ext_irq", 32'(ext_irq), 1);
    rd(6'h23, 32'd5, "claim_prio_5");
    rd(6'h23, 32'd1, "claim_tie_1");
    rd(6'h23, 32'd2, "claim_tie_2");
    rd(6'h23, 32'd0, "claim_empty");

    // Threshold
    do_reset();
    wr(6'h04, 32'd3);
    wr(6'h21, 32'h10);
    wr(6'h22, 32'd3);
    src_irq[3] = 1'b1;
    cyc(5);
    chk("thr3_ext_irq", 32'(ext_irq), 0);
    rd(6'h23, 32'd0, "thr3_claim");
    wr(6'h22, 32'd2);
    cyc(1);
    chk("thr2_ext_irq", 32'(ext_irq), 1);
    rd(6'h23, 32'd4, "thr2_claim");

    // Reset while a source is claimed and another still requests
    do_reset();
    wr(6'h01, 32'd1);
    wr(6'h02, 32'd3);
    wr(6'h21, 32'h06);
    src_irq = 8'h03;
    cyc(4);
    rd(6'h23, 32'd2, "mid_claim_2");
    cyc(1);
    chk("mid_claim_id", 32'(claim_id), 2);
    chk("mid_ext_irq", 32'(ext_irq), 1);
    drain();
    #2;
    rst_n = 1'b0;
    src_irq = '0;
    #1;
    chk("async_rst_ext_irq", 32'(ext_irq), 0);
    chk("async_rst_claim_id", 32'(claim_id), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    rd(6'h01, 32'h0, "post_rst_prio1");
    rd(6'h02, 32'h0, "post_rst_prio2");
    rd(6'h20, 32'h0, "post_rst_pending");
    rd(6'h21, 32'h0, "post_rst_enable");
    rd(6'h22, 32'h0, "post_rst_thr");
    rd(6'h23, 32'h0, "post_rst_claim");

`ifdef RISCV_IRQ_EDGE_EN
    // Edge mode: two pulses while claimed collapse into one re-pend
    do_reset();
    wr(6'h01, 32'd1);
    wr(6'h21, 32'h02);
    wr(6'h24, 32'h02);
    rd(6'h24, 32'h02, "edge_reg");
    src_irq[0] = 1'b1; cyc(1); src_irq[0] = 1'b0;
    cyc(5);
    rd(6'h23, 32'd1, "edge_claim_1");
    src_irq[0] = 1'b1; cyc(1); src_irq[0] = 1'b0;
    cyc(3);
    src_irq[0] = 1'b1; cyc(1); src_irq[0] = 1'b0;
    cyc(4);
    rd(6'h20, 32'h0, "edge_claimed_pending");
    wr(6'h23, 32'd1);
    cyc(1);
    rd(6'h20, 32'h02, "edge_repend");
    rd(6'h23, 32'd1, "edge_claim_2");
    wr(6'h23, 32'd1);
    cyc(2);
    rd(6'h20, 32'h0, "edge_single_repend");
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
